cla_pipelined_addsub: RTL and testbench

//   Parametrised, pipelined carry-lookahead adder/subtractor; successor to the 8-bit combinational CLA.

---
 rtl/cla_pipelined_addsub.sv | 153 +++++++++++++++
 tb/tb_cla_pipelined_addsub.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipelined_addsub.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready stream interface and full backpressure.
// Define CLA_OVF_EN to add the out_ovf signed-overflow output, which travels alongside the result.
module cla_pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef CLA_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NG  = WIDTH / GROUP;
  localparam int GPS = (NG + STAGES - 1) / STAGES;

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign b_eff    = in_sub ? ~in_b : in_b;
  assign c0       = in_sub ? 1'b1 : in_cin;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Each stage owns the bit range [LO,HI); resolved sum bits accumulate low, unresolved p/g travel high.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = GROUP * (((s * GPS) < NG) ? (s * GPS) : NG);
    localparam int HI = GROUP * ((((s + 1) * GPS) < NG) ? ((s + 1) * GPS) : NG);

    logic          valid_i, c_i, c_d;
    logic          valid_q, c_q;
    logic [HI-1:0] sum_d, sum_q;
`ifdef CLA_OVF_EN
    logic          cm_d, cm_q;
`endif

    if (s == 0) begin : g_in
      assign valid_i = in_valid;
      assign c_i     = c0;
    end else begin : g_in
      assign valid_i = g_stage[s-1].valid_q;
      assign c_i     = g_stage[s-1].c_q;
    end

    if (LO < HI) begin : g_work
      logic [WIDTH-1:LO] p_i, g_i;
      logic [HI-1:LO]    sum_w;
      logic              c_w;

      if (s == 0) begin : g_src
        assign p_i = in_a ^ b_eff;
        assign g_i = in_a & b_eff;
      end else begin : g_src
        assign p_i = g_stage[s-1].g_work.g_pg.p_q;
        assign g_i = g_stage[s-1].g_work.g_pg.g_q;
      end

      always_comb begin
        logic c, cb, gp, gg;
        int   idx;
        sum_w = '0;
        c     = c_i;
        for (int k = LO / GROUP; k < HI / GROUP; k++) begin
          gp = 1'b1;
          gg = 1'b0;
          cb = c;
          for (int j = 0; j < GROUP; j++) begin
            idx        = k * GROUP + j;
            sum_w[idx] = p_i[idx] ^ cb;
            cb         = g_i[idx] | (p_i[idx] & cb);
            gg         = g_i[idx] | (p_i[idx] & gg);
            gp         = gp & p_i[idx];
          end
          c = gg | (gp & c);
        end
        c_w = c;
      end

      if (HI < WIDTH) begin : g_pg
        logic [WIDTH-1:HI] p_q, g_q;
        always_ff @(posedge clk) begin
          if (!stall) begin
            p_q <= p_i[WIDTH-1:HI];
            g_q <= g_i[WIDTH-1:HI];
          end
        end
      end

      if (s == 0) begin : g_sum
        assign sum_d = sum_w;
      end else begin : g_sum
        assign sum_d = {sum_w, g_stage[s-1].sum_q};
      end
      assign c_d = c_w;

`ifdef CLA_OVF_EN
      // Carry into the MSB is recovered from its sum and propagate bits.
      if (HI == WIDTH) begin : g_top
        assign cm_d = p_i[WIDTH-1] ^ sum_w[WIDTH-1];
      end else if (s == 0) begin : g_top
        assign cm_d = 1'b0;
      end else begin : g_top
        assign cm_d = g_stage[s-1].cm_q;
      end
`endif
    end else begin : g_pass
      assign sum_d = g_stage[s-1].sum_q;
      assign c_d   = c_i;
`ifdef CLA_OVF_EN
      assign cm_d  = g_stage[s-1].cm_q;
`endif
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
        c_q     <= 1'b0;
`ifdef CLA_OVF_EN
        cm_q    <= 1'b0;
`endif
      end else if (!stall) begin
        valid_q <= valid_i;
        sum_q   <= sum_d;
        c_q     <= c_d;
`ifdef CLA_OVF_EN
        cm_q    <= cm_d;
`endif
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign out_sum   = g_stage[STAGES-1].sum_q;
  assign out_cout  = g_stage[STAGES-1].c_q;
`ifdef CLA_OVF_EN
  assign out_ovf   = g_stage[STAGES-1].c_q ^ g_stage[STAGES-1].cm_q;
`endif

endmodule

// File: tb/tb_cla_pipelined_addsub.sv
// Directed bench for cla_pipelined_addsub (16-bit, group 4, two stages) plus a short streaming scoreboard run.
module tb_cla_pipelined_addsub;

  localparam int WIDTH = 16;
  localparam int NOPS  = 60;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_cin, in_sub;
  logic [WIDTH-1:0] in_a, in_b;
  logic             out_valid, out_ready, out_cout;
  logic [WIDTH-1:0] out_sum;
`ifdef CLA_OVF_EN
  logic             out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_pipelined_addsub #(.WIDTH(WIDTH), .GROUP(4), .STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_cin(in_cin),
    .in_sub(in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_cout(out_cout)
`ifdef CLA_OVF_EN
    ,
    .out_ovf(out_ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic sub);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResult(input string tag, input logic v, input logic [WIDTH-1:0] sum, input logic cout);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'(v));
    checkOutput({tag, "_sum"}, 32'(out_sum), 32'(sum));
    checkOutput({tag, "_cout"}, 32'(out_cout), 32'(cout));
  endtask

  initial begin
    logic [17:0]      exp_q[$];
    logic [17:0]      e;
    logic [16:0]      full;
    logic [WIDTH-1:0] beff, held_sum;
    logic             held, held_cout;
    int               sent, got;

    rst       = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) tick();
    checkResult("reset", 1'b0, 16'h0000, 1'b0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    $display("[TB] latency and wrap-around");
    applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("lat_early_valid", 32'(out_valid), 32'd0);
    tick();
    checkResult("add_wrap", 1'b1, 16'h0000, 1'b1);
    tick();
    checkOutput("add_wrap_gone", 32'(out_valid), 32'd0);

    $display("[TB] subtraction and carry-in, back to back");
    applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 16'h0007, 16'h0005, 1'b0, 1'b1);
    tick();
    checkResult("sub_neg", 1'b1, 16'hFFFE, 1'b0);
    applyStimulus(1'b1, 16'h1234, 16'h0FFF, 1'b1, 1'b0);
    tick();
    checkResult("sub_pos", 1'b1, 16'h0002, 1'b1);
    applyStimulus(1'b1, 16'h0010, 16'h0010, 1'b1, 1'b1);
    tick();
    checkResult("add_cin", 1'b1, 16'h2234, 1'b0);
    applyStimulus(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    tick();
    checkResult("sub_cin_ignored", 1'b1, 16'h0000, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    checkResult("add_group_carry", 1'b1, 16'h0100, 1'b0);
    tick();
    checkOutput("seq_done", 32'(out_valid), 32'd0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h0002, 16'h0002, 1'b0, 1'b0);
    tick();
    checkResult("bb_op1", 1'b1, 16'h0002, 1'b0);
    applyStimulus(1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0);
    out_ready = 1'b0;
    #1;
    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    tick();
    checkResult("bb_hold1", 1'b1, 16'h0002, 1'b0);
    checkOutput("stall_in_ready2", 32'(in_ready), 32'd0);
    tick();
    checkResult("bb_hold2", 1'b1, 16'h0002, 1'b0);
    out_ready = 1'b1;
    #1;
    checkOutput("unstall_in_ready", 32'(in_ready), 32'd1);
    tick();
    checkResult("bb_op2", 1'b1, 16'h0004, 1'b0);
    applyStimulus(1'b1, 16'h0004, 16'h0004, 1'b0, 1'b0);
    tick();
    checkResult("bb_op3", 1'b1, 16'h0006, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    checkResult("bb_op4", 1'b1, 16'h0008, 1'b0);
    tick();
    checkOutput("bb_done", 32'(out_valid), 32'd0);

    $display("[TB] reset with operations in flight");
    applyStimulus(1'b1, 16'h0100, 16'h0200, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h0300, 16'h0400, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    checkResult("rst_mid", 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("rst_no_stale1", 32'(out_valid), 32'd0);
    tick();
    checkOutput("rst_no_stale2", 32'(out_valid), 32'd0);

`ifdef CLA_OVF_EN
    $display("[TB] signed overflow");
    applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
    tick();
    checkResult("ovf_add", 1'b1, 16'h8000, 1'b0);
    checkOutput("ovf_add_flag", 32'(out_ovf), 32'd1);
    applyStimulus(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
    tick();
    checkResult("ovf_sub", 1'b1, 16'h7FFF, 1'b1);
    checkOutput("ovf_sub_flag", 32'(out_ovf), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    checkResult("ovf_none", 1'b1, 16'h0002, 1'b0);
    checkOutput("ovf_none_flag", 32'(out_ovf), 32'd0);
    tick();
`endif

    $display("[TB] streaming with random backpressure");
    sent = 0;
    got  = 0;
    held = 1'b0;
    held_sum  = '0;
    held_cout = 1'b0;
    for (int cyc = 0; cyc < 3000 && got < NOPS; cyc++) begin
      if (sent < NOPS)
        applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (held) begin
        checkOutput("stream_hold_valid", 32'(out_valid), 32'd1);
        checkOutput("stream_hold_sum", 32'(out_sum), 32'(held_sum));
        checkOutput("stream_hold_cout", 32'(out_cout), 32'(held_cout));
      end
      if (in_valid && in_ready) begin
        beff = in_sub ? ~in_b : in_b;
        full = {1'b0, in_a} + {1'b0, beff} + 17'(in_sub ? 1'b1 : in_cin);
        exp_q.push_back({(in_a[WIDTH-1] == beff[WIDTH-1]) && (full[WIDTH-1] != in_a[WIDTH-1]), full});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("stream_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("stream_sum", 32'(out_sum), 32'(e[WIDTH-1:0]));
          checkOutput("stream_cout", 32'(out_cout), 32'(e[WIDTH]));
`ifdef CLA_OVF_EN
          checkOutput("stream_ovf", 32'(out_ovf), 32'(e[WIDTH+1]));
`endif
        end
        got++;
      end
      held      = out_valid & ~out_ready;
      held_sum  = out_sum;
      held_cout = out_cout;
      tick();
    end
    checkOutput("stream_count", 32'(got), 32'(NOPS));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
